sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester controller for the single-port fakeram45_64x7 macro (64 words × 7 bits, bit-masked writes, registered read data). It clears the array after reset, then shares the one port between requester A and requester B. Arbitration is round-robin over valid/ready handshakes, and each requester gets a read-response channel. It sits between the requesting logic and the macro's `ce_in`/`we_in`/`addr_in`/`wd_in`/`w_mask_in`/`rd_out` pins.

## Interface
- `ADDR_W`, 6: address width; the macro has 64 words.
- `DATA_W`, 7: data and mask width.
- `INIT_CLEAR`, 1: 1 = zero-fill the array after reset; 0 = skip the fill.
- `clk` in 1: single clock, also drives the macro `clk`.
- `rst_n` in 1: reset, **synchronous, active-low**. One clock only; no other clock or reset exists.
- `a_req_valid` / `b_req_valid` in 1: request present.
- `a_req_ready` / `b_req_ready` out 1: request accepted this cycle when valid && ready.
- `a_req_we` / `b_req_we` in 1: 1 = write, 0 = read.
- `a_req_addr` / `b_req_addr` in `ADDR_W`: word address.
- `a_req_wdata` / `b_req_wdata` in `DATA_W`: write data.
- `a_req_wmask` / `b_req_wmask` in `DATA_W`: per-bit write enable, 1 = write that bit.
- `a_rsp_valid` / `b_rsp_valid` out 1: read data valid, single-cycle pulse. No backpressure.
- `a_rsp_rdata` / `b_rsp_rdata` out `DATA_W`: read data.
- `mem_ce` out 1: macro `ce_in`.
- `mem_we` out 1: macro `we_in`.
- `mem_addr` out `ADDR_W`: macro `addr_in`.
- `mem_wd` out `DATA_W`: macro `wd_in`.
- `mem_wmask` out `DATA_W`: macro `w_mask_in`.
- `mem_rd` in `DATA_W`: macro `rd_out`.
- `init_done` out 1: high once the block is in RUN.

## Operation
- **States:**
  - INIT: entered on reset when `INIT_CLEAR`=1.
  - RUN: otherwise.
- **INIT:**
  - A 6-bit sweep counter starts at 0.
  - Each cycle drives `mem_ce`=1, `mem_we`=1, `mem_addr`=counter, `mem_wd`=0, `mem_wmask`=all-ones.
  - The counter wraps from 63 to 0 and the state moves to RUN, giving exactly 64 write cycles.
  - Both `req_ready` are 0 throughout INIT.
- **RUN arbitration:**
  - Only one valid: that requester gets `ready`=1.
  - Both valid: grant goes to the side not granted most recently. A 1-bit `last_grant` flag, reset value A, means B wins the first tie.
  - `last_grant` updates only on an accepted handshake.
  - No valid: `mem_ce`=0 and `last_grant` holds.
- **Macro drive:**
  - `mem_*` is a combinational mux of the granted request, so the access occurs at the same edge as the handshake.
  - `mem_we` = `req_we`. On reads, `mem_wmask` and `mem_wd` are forced to 0.
- **Read response:**
  - The `rsp_valid` of the granting side is registered high in the cycle after the handshake.
  - `rsp_rdata` = `mem_rd` in that cycle, passed through unregistered.
  - Both `rsp_rdata` buses carry `mem_rd`; consumers qualify with their own `rsp_valid`.
- **Writes:** produce no response.
- **Back-to-back:**
  - A read may be accepted every cycle, with one response per cycle.
  - A write to address X followed next cycle by a read of X returns the new data.
- **Hazards:** A request may change while `ready`=0. The block captures nothing until handshake.

## Timing
- **Reset values:**
  - Both `req_ready`=0, both `rsp_valid`=0, `mem_ce`=0, `init_done`=0.
  - If `INIT_CLEAR`=1, the sweep counter is 0 and state is INIT.
  - If `INIT_CLEAR`=0, `init_done` is 1 from the first cycle after reset.
- **Init duration:** with `INIT_CLEAR`=1, `init_done` rises in the cycle after the 64th clear write, i.e. cycle 64 counting the first post-reset cycle as 0.
- **Read latency:** 1 cycle from handshake to `rsp_valid`.
- **`ready`:** combinational from state, the two valids and `last_grant`. It never depends on `ready` itself.
- **Reset mid-operation:**
  - A pending `rsp_valid` is dropped.
  - The sweep restarts at address 0.
  - `last_grant` returns to A.
- **Illegal input:** `rst_n` low while valids are high is legal; no handshake occurs.

## Structure
- **Package `sram_arb_pkg`:**
  - `ADDR_W`, `DATA_W`, `DEPTH`=64.
  - `state_e` enum {INIT, RUN}.
  - `mem_req_t` struct {we, addr, wdata, wmask}.
- **Sub-module `rr_arb2`:**
  - Inputs: two valids.
  - Outputs: one-hot grant.
  - Holds `last_grant` and the update-on-accept logic.
- **Top module:** holds the FSM, the sweep counter, the request mux and the response registers.

## Test plan
- **Init sweep:**
  - Stimulus: release reset with `INIT_CLEAR`=1 and both valids high.
  - Required: `ready` stays 0 for 64 cycles, `mem_addr` goes 0..63 with `mem_wd`=0 and mask 7'h7F, and `init_done` goes to 1 at cycle 64.
- **Masked write/read:**
  - Stimulus: A writes addr 5 with data 7'h55 and mask 7'h0F, then reads addr 5.
  - Required: `a_rsp_valid` one cycle later with `a_rsp_rdata`=7'h05.
- **Tie arbitration:**
  - Stimulus: A and B read continuously for 6 cycles.
  - Required: grants alternate B, A, B, A, B, A, with the matching `rsp_valid` each following cycle and never both high.
- **Write-then-read same address across requesters:**
  - Stimulus: B writes addr 63 with 7'h7F (full mask), then A reads addr 63.
  - Required: A receives 7'h7F.
- **Reset mid-sweep:**
  - Stimulus: assert `rst_n`=0 at sweep address 30.
  - Required: after release, the sweep restarts at 0, `init_done` goes to 1 exactly 64 cycles later, and no `rsp_valid` appears.
- **Idle:**
  - Stimulus: RUN with both valids low.
  - Required: `mem_ce`=0 and `last_grant` unchanged.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared widths, FSM states and the request bundle for the two-port SRAM arbiter.
package sram_arb_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 7;
    localparam int DEPTH  = 64;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] wmask;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant[0] = A, grant[1] = B. Remembers the last
// accepted side and awards a tie to the other one.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    // 0 = A granted most recently, 1 = B
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (&valid) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end

        last_grant_d = last_grant_q;
        if (grant[0]) begin
            last_grant_d = 1'b0;
        end else if (grant[1]) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port 64x7 SRAM macro between requesters A and B, after an
// optional zero-fill sweep that runs once per reset.
module sram_port_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 7,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    input  logic [DATA_W-1:0] a_req_wmask,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    input  logic [DATA_W-1:0] b_req_wmask,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,

    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic [DATA_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rd,

    output logic              init_done
);

    import sram_arb_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              init_done_q, init_done_d;
    logic              a_rsp_valid_q, a_rsp_valid_d;
    logic              b_rsp_valid_q, b_rsp_valid_d;

    logic              run;
    logic [1:0]        grant;
    mem_req_t          a_req, b_req, sel_req;

    assign a_req = '{we: a_req_we, addr: a_req_addr, wdata: a_req_wdata, wmask: a_req_wmask};
    assign b_req = '{we: b_req_we, addr: b_req_addr, wdata: b_req_wdata, wmask: b_req_wmask};

    // init_done_q is low throughout reset, so no handshake can slip through
    // while rst_n is asserted even when the sweep is disabled.
    assign run = (state_q == RUN) && init_done_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .valid ({b_req_valid, a_req_valid}),
        .grant (grant)
    );

    assign a_req_ready = grant[0];
    assign b_req_ready = grant[1];

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == INIT) begin
            sweep_d = sweep_q + ADDR_W'(1);
            if (&sweep_q) begin
                state_d = RUN;
            end
        end
        init_done_d   = (state_d == RUN);
        a_rsp_valid_d = grant[0] & ~a_req_we;
        b_rsp_valid_d = grant[1] & ~b_req_we;
    end

    always_comb begin
        sel_req   = grant[1] ? b_req : a_req;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wd    = '0;
        mem_wmask = '0;
        if (state_q == INIT) begin
            mem_ce    = rst_n;
            mem_we    = 1'b1;
            mem_addr  = sweep_q;
            mem_wmask = '1;
        end else if (|grant) begin
            mem_ce   = 1'b1;
            mem_we   = sel_req.we;
            mem_addr = sel_req.addr;
            if (sel_req.we) begin
                mem_wd    = sel_req.wdata;
                mem_wmask = sel_req.wmask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= INIT_CLEAR ? INIT : RUN;
            sweep_q       <= '0;
            init_done_q   <= 1'b0;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_q       <= sweep_d;
            init_done_q   <= init_done_d;
            a_rsp_valid_q <= a_rsp_valid_d;
            b_rsp_valid_q <= b_rsp_valid_d;
        end
    end

    // Macro read data is already registered; both sides see it and qualify
    // with their own valid.
    assign a_rsp_valid = a_rsp_valid_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign a_rsp_rdata = mem_rd;
    assign b_rsp_rdata = mem_rd;
    assign init_done   = init_done_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter with a behavioural 64x7 macro and a read scoreboard.
module tb_sram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req_valid, a_req_ready, a_req_we;
    logic [5:0] a_req_addr;
    logic [6:0] a_req_wdata, a_req_wmask;
    logic       a_rsp_valid;
    logic [6:0] a_rsp_rdata;
    logic       b_req_valid, b_req_ready, b_req_we;
    logic [5:0] b_req_addr;
    logic [6:0] b_req_wdata, b_req_wmask;
    logic       b_rsp_valid;
    logic [6:0] b_rsp_rdata;
    logic       mem_ce, mem_we;
    logic [5:0] mem_addr;
    logic [6:0] mem_wd, mem_wmask;
    logic [6:0] mem_rd = 7'h00;
    logic       init_done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit         side;
        logic [6:0] data;
    } exp_t;
    exp_t       exp_q[$];
    logic [6:0] ref_mem[64];

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(6), .DATA_W(7), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_req_wmask(a_req_wmask),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_req_wmask(b_req_wmask),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_wmask(mem_wmask), .mem_rd(mem_rd), .init_done(init_done)
    );

    // Macro stand-in: random power-up contents, bit-masked writes, registered reads.
    logic [6:0] macro_mem[64];
    bit         primed = 1'b0;
    always @(posedge clk) begin
        if (!primed) begin
            for (int i = 0; i < 64; i++) macro_mem[i] <= 7'($urandom);
            primed <= 1'b1;
        end else if (mem_ce) begin
            if (mem_we)
                macro_mem[mem_addr] <= (macro_mem[mem_addr] & ~mem_wmask) | (mem_wd & mem_wmask);
            else
                mem_rd <= macro_mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: reads push the expected word at the handshake, responses pop it.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < 64; i++) ref_mem[i] = 7'h00;
        end else begin
            if (a_rsp_valid || b_rsp_valid) begin
                check("rsp_onehot", 32'(a_rsp_valid & b_rsp_valid), 32'd0);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_side", 32'(b_rsp_valid), 32'(e.side));
                    check("rsp_data", 32'(a_rsp_valid ? a_rsp_rdata : b_rsp_rdata), 32'(e.data));
                    $display("rsp %s data=0x%02h", b_rsp_valid ? "B" : "A",
                             a_rsp_valid ? a_rsp_rdata : b_rsp_rdata);
                end
            end
            if (a_req_valid && a_req_ready) begin
                if (a_req_we)
                    ref_mem[a_req_addr] = (ref_mem[a_req_addr] & ~a_req_wmask) | (a_req_wdata & a_req_wmask);
                else
                    exp_q.push_back('{side: 1'b0, data: ref_mem[a_req_addr]});
            end
            if (b_req_valid && b_req_ready) begin
                if (b_req_we)
                    ref_mem[b_req_addr] = (ref_mem[b_req_addr] & ~b_req_wmask) | (b_req_wdata & b_req_wmask);
                else
                    exp_q.push_back('{side: 1'b1, data: ref_mem[b_req_addr]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic both_read(input logic [5:0] aa, input logic [5:0] ba);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = aa;
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = ba;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the handshake edge.
    task automatic issue(input bit side, input bit we, input logic [5:0] addr,
                         input logic [6:0] wd, input logic [6:0] wm);
        bit ok = 1'b0;
        if (!side) begin
            a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_wmask = wm;
        end else begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd; b_req_wmask = wm;
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (side ? b_req_ready : a_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("issue_timeout", 32'd0, 32'd1);
        step();
        if (!side) a_req_valid = 1'b0;
        else       b_req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("reset_outputs", 32'({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, mem_ce, init_done}), 32'd0);
    endtask

    // Entered at posedge+1 just after rst_n rises, with both valids held high.
    task automatic check_sweep();
        logic [5:0] cc;
        for (int c = 0; c < 64; c++) begin
            cc = 6'(c);
            @(negedge clk);
            check("sweep",
                  32'({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, mem_ce, mem_we, init_done,
                       mem_addr, mem_wd, mem_wmask}),
                  32'({4'b0000, 1'b1, 1'b1, 1'b0, cc, 7'h00, 7'h7F}));
        end
        @(negedge clk);
        check("init_done_at_64", 32'(init_done), 32'd1);
        check("first_tie_to_b", 32'({a_req_ready, b_req_ready}), 32'b01);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        a_req_wdata = 7'h00; a_req_wmask = 7'h00;
        b_req_wdata = 7'h00; b_req_wmask = 7'h00;
        both_read(6'd0, 6'd1);
        repeat (3) @(posedge clk);
        check_reset_outputs();

        // Sweep with both requesters pushing the whole time
        step();
        rst_n = 1'b1;
        check_sweep();
        step();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;

        issue(1'b1, 1'b1, 6'd20, 7'h22, 7'h7F);
        issue(1'b0, 1'b1, 6'd10, 7'h11, 7'h7F);

        // Continuous tie after A was granted last: B, A, B, A, B, A
        both_read(6'd10, 6'd20);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("tie_grant", 32'({a_req_ready, b_req_ready}), (k % 2 == 0) ? 32'b01 : 32'b10);
            step();
        end
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;

        issue(1'b0, 1'b1, 6'd5, 7'h55, 7'h0F);
        issue(1'b0, 1'b0, 6'd5, 7'h00, 7'h00);
        @(negedge clk);
        check("masked_rsp", 32'({a_rsp_valid, a_rsp_rdata}), 32'({1'b1, 7'h05}));
        step();

        issue(1'b1, 1'b1, 6'd63, 7'h7F, 7'h7F);
        issue(1'b0, 1'b0, 6'd63, 7'h00, 7'h00);
        @(negedge clk);
        check("cross_rsp", 32'({a_rsp_valid, a_rsp_rdata}), 32'({1'b1, 7'h7F}));
        step();

        // Idle: no access, and A (granted last) must still lose the next tie
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle", 32'({mem_ce, a_req_ready, b_req_ready}), 32'd0);
            step();
        end
        both_read(6'd1, 6'd2);
        @(negedge clk);
        check("idle_last_grant", 32'({a_req_ready, b_req_ready}), 32'b01);
        step();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        step();
        step();

        // Reset in the middle of a fresh sweep
        both_read(6'd3, 6'd4);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (mem_addr == 6'd30) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_addr30", 32'(found), 32'd1);
        rst_n = 1'b0;
        step();
        step();
        check_reset_outputs();
        step();
        rst_n = 1'b1;
        check_sweep();
        step();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        step();
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
